di_arbiter: RTL and testbench

Two-master arbiter and transaction sequencer for the device-interface register bus (endpoint address, register address, write data, read data, write/read strobes, ready). Master 0 is the host-interface register path; master 1 is an on-chip requester, such as a local configuration sequencer. The block grants one complete transaction at a time, drives the bus, waits for the device-side ready, and returns data and completion to the granted master. A watchdog guarantees completion.

---
 rtl/di_arbiter_if.sv | 44 ++++
 rtl/di_arbiter.sv | 143 ++++++++++++++
 tb/tb_di_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/di_arbiter_if.sv
// Device-interface register bus between two requesting masters, the arbiter and the device.
// The arbiter takes the slave view; a master-side model or bench takes the master view.
interface di_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_write;
    logic        m1_write;
    logic [15:0] m0_ep;
    logic [15:0] m1_ep;
    logic [15:0] m0_addr;
    logic [15:0] m1_addr;
    logic [15:0] m0_wdata;
    logic [15:0] m1_wdata;
    logic        m0_ack;
    logic        m1_ack;
    logic [15:0] m_rdata;
    logic        m_err;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] di_ep_addr;
    logic [15:0] di_reg_addr;
    logic [15:0] di_data_in;
    logic        di_write;
    logic        di_read;
    logic [15:0] di_data_out;
    logic        di_ready;

    // Handshake: a master holds req (with stable write/ep/addr/wdata) until it sees its
    // one-cycle ack, and drops req on the edge at which that ack is sampled high.
    // The device sees one-cycle di_write/di_read strobes and answers with di_ready.
    modport slave (
        input  m0_req, m1_req, m0_write, m1_write, m0_ep, m1_ep,
               m0_addr, m1_addr, m0_wdata, m1_wdata, di_data_out, di_ready,
        output m0_ack, m1_ack, m_rdata, m_err, grant, busy,
               di_ep_addr, di_reg_addr, di_data_in, di_write, di_read
    );

    modport master (
        output m0_req, m1_req, m0_write, m1_write, m0_ep, m1_ep,
               m0_addr, m1_addr, m0_wdata, m1_wdata, di_data_out, di_ready,
        input  m0_ack, m1_ack, m_rdata, m_err, grant, busy,
               di_ep_addr, di_reg_addr, di_data_in, di_write, di_read
    );
endinterface

// File: rtl/di_arbiter.sv
// Two-master arbiter and sequencer for the device-interface register bus: one complete
// transaction at a time, with a watchdog forcing an error completion if the device stalls.
module di_arbiter #(
    parameter bit          FIXED_PRIO     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic        if_clock,
    input  logic        resetb,
    di_arbiter_if.slave bus,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q;
    logic            last_m1_q;
    logic [1:0]      grant_q;
    logic            busy_q;
    logic            m0_ack_q;
    logic            m1_ack_q;
    logic [15:0]     rdata_q;
    logic            err_q;
    logic [15:0]     ep_q;
    logic [15:0]     reg_q;
    logic [15:0]     din_q;
    logic            wr_q;
    logic            di_write_q;
    logic            di_read_q;
    logic [TO_W-1:0] cnt_q;

    logic            req_any;
    logic            sel_m1;
    logic [15:0]     ep_d;
    logic [15:0]     reg_d;
    logic [15:0]     din_d;
    logic            wr_d;

    // last_m1_q remembers the previous owner so a tie goes to the other master.
    always_comb begin
        req_any = bus.m0_req | bus.m1_req;
        sel_m1  = 1'b0;
        if (bus.m1_req && !bus.m0_req)
            sel_m1 = 1'b1;
        else if (bus.m0_req && bus.m1_req && !FIXED_PRIO && !last_m1_q)
            sel_m1 = 1'b1;
        ep_d  = sel_m1 ? bus.m1_ep    : bus.m0_ep;
        reg_d = sel_m1 ? bus.m1_addr  : bus.m0_addr;
        din_d = sel_m1 ? bus.m1_wdata : bus.m0_wdata;
        wr_d  = sel_m1 ? bus.m1_write : bus.m0_write;
    end

    always_ff @(posedge if_clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            last_m1_q  <= 1'b1;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            ep_q       <= '0;
            reg_q      <= '0;
            din_q      <= '0;
            wr_q       <= 1'b0;
            di_write_q <= 1'b0;
            di_read_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            di_write_q <= 1'b0;
            di_read_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        ep_q       <= ep_d;
                        reg_q      <= reg_d;
                        din_q      <= din_d;
                        wr_q       <= wr_d;
                        di_write_q <= wr_d;
                        di_read_q  <= !wr_d;
                        last_m1_q  <= sel_m1;
                        grant_q    <= sel_m1 ? 2'b10 : 2'b01;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Ready on the timeout edge still counts as a normal completion.
                    if (bus.di_ready) begin
                        if (!wr_q)
                            rdata_q <= bus.di_data_out;
                        err_q    <= 1'b0;
                        m0_ack_q <= grant_q[0];
                        m1_ack_q <= grant_q[1];
                        state_q  <= S_DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
                        rdata_q  <= 16'hDEAD;
                        err_q    <= 1'b1;
                        m0_ack_q <= grant_q[0];
                        m1_ack_q <= grant_q[1];
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                S_DONE: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.m0_ack      = m0_ack_q;
    assign bus.m1_ack      = m1_ack_q;
    assign bus.m_rdata     = rdata_q;
    assign bus.m_err       = err_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.di_ep_addr  = ep_q;
    assign bus.di_reg_addr = reg_q;
    assign bus.di_data_in  = din_q;
    assign bus.di_write    = di_write_q;
    assign bus.di_read     = di_read_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_di_arbiter.sv
// Bench for di_arbiter: DUT 0 is round-robin with the default watchdog, DUT 1 is fixed
// priority with a 4-cycle watchdog. Drivers push expectations; a negedge monitor pops them.
module tb_di_arbiter;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  logic        req [2][2];
  logic        wr  [2][2];
  logic [15:0] ep  [2][2];
  logic [15:0] ad  [2][2];
  logic [15:0] wd  [2][2];
  logic        ack [2][2];
  logic [15:0] rdata [2];
  logic        err   [2];
  logic [1:0]  grant [2];
  logic        busy  [2];
  logic [15:0] di_ep [2];
  logic [15:0] di_reg [2];
  logic [15:0] di_din [2];
  logic        di_w  [2];
  logic        di_r  [2];
  logic [15:0] di_dout [2];
  logic        di_rdy [2];
  logic [1:0]  st [2];

  int          dly [2];
  logic [15:0] dev [2];
  logic [15:0] rdata_m [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Expectation queues indexed by dut*2+master.
  logic [48:0] bus_q [4][$];
  logic [16:0] ack_q [4][$];
  logic [1:0]  glog  [2][$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    di_arbiter_if bus ();
    assign bus.m0_req = req[g][0];  assign bus.m1_req = req[g][1];
    assign bus.m0_write = wr[g][0]; assign bus.m1_write = wr[g][1];
    assign bus.m0_ep = ep[g][0];    assign bus.m1_ep = ep[g][1];
    assign bus.m0_addr = ad[g][0];  assign bus.m1_addr = ad[g][1];
    assign bus.m0_wdata = wd[g][0]; assign bus.m1_wdata = wd[g][1];
    assign bus.di_data_out = di_dout[g];
    assign bus.di_ready = di_rdy[g];
    assign ack[g][0] = bus.m0_ack;  assign ack[g][1] = bus.m1_ack;
    assign rdata[g] = bus.m_rdata;  assign err[g] = bus.m_err;
    assign grant[g] = bus.grant;    assign busy[g] = bus.busy;
    assign di_ep[g] = bus.di_ep_addr;
    assign di_reg[g] = bus.di_reg_addr;
    assign di_din[g] = bus.di_data_in;
    assign di_w[g] = bus.di_write;  assign di_r[g] = bus.di_read;

    di_arbiter #(
      .FIXED_PRIO(g == 1),
      .TIMEOUT_CYCLES((g == 1) ? 32'd4 : 32'd255),
      .TO_W(8)
    ) u_dut (
      .if_clock(clk),
      .resetb(resetb),
      .bus(bus),
      .state_o(st[g])
    );

    // Device model: answers each strobe with one di_ready pulse after dly[g] extra cycles.
    initial begin
      forever begin
        @(negedge clk);
        if ((di_w[g] || di_r[g]) && dly[g] >= 0) begin
          @(posedge clk); #1;
          repeat (dly[g]) begin @(posedge clk); #1; end
          di_dout[g] = dev[g];
          di_rdy[g] = 1'b1;
          @(posedge clk); #1;
          di_rdy[g] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: every strobe and every ack must match the oldest expectation for its master.
  always @(negedge clk) begin
    int k;
    logic [48:0] be;
    logic [16:0] ae;
    if (resetb) begin
      for (int d = 0; d < 2; d++) begin
        if (di_w[d] || di_r[d]) begin
          glog[d].push_back(grant[d]);
          chk("strobe_excl", 64'(di_w[d] & di_r[d]), 64'd0);
          chk("strobe_busy", 64'(busy[d]), 64'd1);
          if (grant[d] == 2'b01) k = d * 2;
          else if (grant[d] == 2'b10) k = d * 2 + 1;
          else k = -1;
          if (k < 0) miss("strobe_grant_onehot");
          else if (bus_q[k].size() == 0) miss("strobe_unexpected");
          else begin
            be = bus_q[k].pop_front();
            chk("strobe_bus", 64'({di_w[d], di_ep[d], di_reg[d], di_din[d]}), 64'(be));
          end
        end
        for (int m = 0; m < 2; m++) begin
          if (ack[d][m]) begin
            chk("ack_grant", 64'(grant[d]), (m == 0) ? 64'd1 : 64'd2);
            chk("ack_excl", 64'(ack[d][0] & ack[d][1]), 64'd0);
            if (ack_q[d*2+m].size() == 0) miss("ack_unexpected");
            else begin
              ae = ack_q[d*2+m].pop_front();
              chk("ack_data", 64'({err[d], rdata[d]}), 64'(ae));
            end
          end
        end
      end
    end
  end

  // Issue one transaction and wait (bounded) for its ack; exp_lat < 0 skips the latency check.
  task automatic txn(input int d, input int m, input logic w, input logic [15:0] e,
                     input logic [15:0] a, input logic [15:0] x, input int exp_lat,
                     input logic keep);
    int t0;
    int n;
    logic ee;
    logic [15:0] er;
    ee = (d == 1) && (dly[d] < 0);
    er = ee ? 16'hDEAD : (w ? rdata_m[d] : dev[d]);
    rdata_m[d] = er;
    bus_q[d*2+m].push_back({w, e, a, x});
    ack_q[d*2+m].push_back({ee, er});
    wr[d][m] = w; ep[d][m] = e; ad[d][m] = a; wd[d][m] = x;
    req[d][m] = 1'b1;
    t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack[d][m] && n < 200);
    if (!ack[d][m]) miss("ack_timeout");
    else if (exp_lat >= 0) chk("latency", 64'(cyc - t0), 64'(exp_lat));
    @(posedge clk); #1;
    if (!keep) req[d][m] = 1'b0;
  endtask

  task automatic chk_order(input int d, input int len, input logic [7:0] exp);
    logic [7:0] seq;
    seq = '0;
    for (int i = 0; i < glog[d].size() && i < 4; i++) seq = {seq[5:0], glog[d][i]};
    chk("grant_count", 64'(glog[d].size()), 64'(len));
    chk("grant_order", 64'(seq), 64'(exp));
  endtask

  task automatic chk_zero();
    for (int d = 0; d < 2; d++) begin
      chk("rst_bus", 64'({di_ep[d], di_reg[d], di_din[d]}), 64'd0);
      chk("rst_ctl", 64'({ack[d][0], ack[d][1], rdata[d], err[d], grant[d], busy[d],
                          di_w[d], di_r[d], st[d]}), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; wr[d][m] = 1'b0;
        ep[d][m] = '0; ad[d][m] = '0; wd[d][m] = '0;
      end
      di_dout[d] = '0; di_rdy[d] = 1'b0;
      dly[d] = 0; dev[d] = '0; rdata_m[d] = '0;
    end
    #12;
    chk_zero();
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    @(posedge clk); #1;

    // Single read, minimum latency.
    dly[0] = 0; dev[0] = 16'hBEEF;
    txn(0, 0, 1'b0, 16'd3, 16'h0010, 16'h0000, 3, 1'b0);

    // Write with ready 5 cycles late; m_rdata keeps BEEF.
    dly[0] = 5; dev[0] = 16'hFFFF;
    txn(0, 1, 1'b1, 16'd7, 16'h0022, 16'h1234, 8, 1'b0);

    // Round-robin contention, both masters back-to-back.
    dly[0] = 0; dev[0] = 16'h600D;
    glog[0].delete();
    fork
      begin
        txn(0, 0, 1'b0, 16'd1, 16'h0050, 16'h0A0A, -1, 1'b1);
        txn(0, 0, 1'b0, 16'd1, 16'h0051, 16'h0B0B, -1, 1'b0);
      end
      begin
        txn(0, 1, 1'b0, 16'd2, 16'h0060, 16'h0C0C, -1, 1'b1);
        txn(0, 1, 1'b0, 16'd2, 16'h0061, 16'h0D0D, -1, 1'b0);
      end
    join
    chk_order(0, 4, 8'b01_10_01_10);

    // Fixed priority: m0 re-requests continuously, m1 waits until m0 lets go.
    dly[1] = 0; dev[1] = 16'h7777;
    glog[1].delete();
    fork
      begin
        txn(1, 0, 1'b0, 16'd4, 16'h0070, 16'h0000, -1, 1'b1);
        txn(1, 0, 1'b1, 16'd4, 16'h0071, 16'h5151, -1, 1'b1);
        txn(1, 0, 1'b0, 16'd4, 16'h0072, 16'h0000, -1, 1'b0);
      end
      txn(1, 1, 1'b0, 16'd5, 16'h0080, 16'h0000, -1, 1'b0);
    join
    chk_order(1, 4, 8'b01_01_01_10);

    // Watchdog: timeout, ready exactly on the timeout edge, then a normal read.
    dly[1] = -1;
    txn(1, 0, 1'b0, 16'd5, 16'h0030, 16'h0000, 6, 1'b0);
    dly[1] = 3; dev[1] = 16'h2222;
    txn(1, 1, 1'b0, 16'd6, 16'h0031, 16'h0000, 6, 1'b0);
    dly[1] = 0; dev[1] = 16'h1111;
    txn(1, 0, 1'b0, 16'd6, 16'h0032, 16'h0000, 3, 1'b0);

    // Late req drop: the extra cycle of req is a second full transaction.
    dly[0] = 0; dev[0] = 16'h3333;
    glog[0].delete();
    txn(0, 0, 1'b0, 16'd3, 16'h0040, 16'h0000, 3, 1'b1);
    dev[0] = 16'h4444;
    txn(0, 0, 1'b0, 16'd3, 16'h0041, 16'h0000, 3, 1'b0);
    chk_order(0, 2, 8'b00_00_01_01);

    // Reset while waiting on the device: everything clears, no ack follows.
    dly[0] = -1;
    bus_q[0].push_back({1'b0, 16'd9, 16'h0090, 16'h0000});
    wr[0][0] = 1'b0; ep[0][0] = 16'd9; ad[0][0] = 16'h0090; wd[0][0] = 16'h0000;
    req[0][0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_wait_state", 64'(st[0]), 64'd2);
    resetb = 1'b0;
    #1;
    chk_zero();
    req[0][0] = 1'b0;
    rdata_m[0] = '0; rdata_m[1] = '0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_ack_after_reset", 64'(ack_q[0].size()), 64'd0);

    // Fresh tie after reset: master 0 must win first.
    dly[0] = 0; dev[0] = 16'h5555;
    glog[0].delete();
    fork
      txn(0, 0, 1'b0, 16'd10, 16'h00A0, 16'h0000, 3, 1'b0);
      txn(0, 1, 1'b0, 16'd11, 16'h00B0, 16'h0000, -1, 1'b0);
    join
    chk_order(0, 2, 8'b00_00_01_10);

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      chk("queue_drain", 64'(bus_q[k].size() + ack_q[k].size()), 64'd0);
    for (int d = 0; d < 2; d++)
      chk("idle_state", 64'({grant[d], busy[d], st[d]}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
